// File: rtl/writeback_pkg.sv
// -----------------------------------------------------------------------------
// writeback_pkg
// Shared definitions for the write-back stage: data width and the encoding of
// the result-source select driven by the decode stage.
//
// Contents:
//   XLEN         - register/data width (32)
//   SEL_W        - result-source select width (2)
//   WB_SEL_*     - select encodings (memory, ALU, PC+4, reserved)
//   wb_sel_e     - enum view of the select, for readable debug/case labels
//   wb_sel_valid - true for the three defined encodings
// -----------------------------------------------------------------------------
package writeback_pkg;

  localparam int XLEN  = 32;
  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] WB_SEL_MEM  = 2'b00;
  localparam logic [SEL_W-1:0] WB_SEL_ALU  = 2'b01;
  localparam logic [SEL_W-1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [SEL_W-1:0] WB_SEL_RSVD = 2'b11;

  typedef enum logic [SEL_W-1:0] {
    SEL_MEM  = 2'b00,
    SEL_ALU  = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_RSVD = 2'b11
  } wb_sel_e;

  // The reserved encoding is the only invalid one.
  function automatic logic wb_sel_valid(input logic [SEL_W-1:0] sel);
    return (sel != WB_SEL_RSVD);
  endfunction

endpackage

// File: rtl/writeback_mux3.sv
// -----------------------------------------------------------------------------
// wb_mux3
// Three-input result-source selector for the write-back stage. The chosen
// input passes through bit-exact; the reserved select value yields zero so a
// bad decode never leaks stale data into the register file.
//
// Ports:
//   sel   in  [1:0]  source select (00 mem, 01 alu, 10 pc4, 11 -> zero)
//   mem   in  [31:0] load data
//   alu   in  [31:0] ALU result
//   pc4   in  [31:0] link value (PC+4)
//   dout  out [31:0] selected value
// -----------------------------------------------------------------------------
module wb_mux3
  import writeback_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [XLEN-1:0]  mem,
  input  logic [XLEN-1:0]  alu,
  input  logic [XLEN-1:0]  pc4,
  output logic [XLEN-1:0]  dout
);

  always_comb begin
    dout = '0;
    case (sel)
      WB_SEL_MEM: dout = mem;
      WB_SEL_ALU: dout = alu;
      WB_SEL_PC4: dout = pc4;
      default:    dout = '0;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
// Write-back stage of the pipeline. Chooses the register-file write value from
// load data, ALU result or PC+4. The result path is purely combinational and
// independent of clk, rst and regwriteW; the register file gates the write.
//
// A small amount of debug state (observable hierarchically only) tracks the
// most recent written value and the number of write-backs performed.
//
// Optional build macro:
//   WRITEBACK_CHECK_EN - adds simulation-only checks for writes with the
//                        reserved select or with an unknown select.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   synchronous active-high reset (debug state only)
//   regwriteW  in   1   register-file write enable for this instruction
//   wbselW     in   2   result source select
//   data_readW in  32   load data
//   ALUresW    in  32   ALU result
//   pc4W       in  32   PC+4 link value
//   resultW    out 32   value to write to the register file
// -----------------------------------------------------------------------------
module writeback
  import writeback_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             regwriteW,
  input  logic [SEL_W-1:0] wbselW,
  input  logic [XLEN-1:0]  data_readW,
  input  logic [XLEN-1:0]  ALUresW,
  input  logic [XLEN-1:0]  pc4W,
  output logic [XLEN-1:0]  resultW
);

  logic [XLEN-1:0] last_resultW;
  logic [XLEN-1:0] wb_countW;

  wb_mux3 u_mux (
    .sel  (wbselW),
    .mem  (data_readW),
    .alu  (ALUresW),
    .pc4  (pc4W),
    .dout (resultW)
  );

  // Debug shadow state. A floating rst reads as X/Z, which the if() treats as
  // false, so an unconnected reset behaves as deasserted. Reset wins over a
  // simultaneous write. The counter wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_resultW <= '0;
      wb_countW    <= '0;
    end else if (regwriteW) begin
      last_resultW <= resultW;
      wb_countW    <= wb_countW + 32'd1;
    end
  end

`ifdef WRITEBACK_CHECK_EN
  always @(posedge clk) begin
    if (regwriteW === 1'b1) begin
      if ($isunknown(wbselW))
        $error("writeback: wbselW is X/Z while regwriteW=1 (wbselW=%b)", wbselW);
      else if (!wb_sel_valid(wbselW))
        $error("writeback: register write with reserved wbselW=%b", wbselW);
    end
  end
`endif

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;
  import writeback_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        regwriteW;
  logic [1:0]  wbselW;
  logic [31:0] data_readW;
  logic [31:0] ALUresW;
  logic [31:0] pc4W;
  logic [31:0] resultW;

  int checks = 0;
  int errors = 0;

  writeback dut (
    .clk        (clk),
    .rst        (rst),
    .regwriteW  (regwriteW),
    .wbselW     (wbselW),
    .data_readW (data_readW),
    .ALUresW    (ALUresW),
    .pc4W       (pc4W),
    .resultW    (resultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    regwriteW  = 1'b0;
    wbselW     = WB_SEL_MEM;
    data_readW = 32'h0;
    ALUresW    = 32'h0;
    pc4W       = 32'h0;
    tick();
    check("reset_count", dut.wb_countW, 32'd0);
    check("reset_last", dut.last_resultW, 32'd0);

    // Select each source with distinct patterns; one write per edge.
    rst        = 1'b0;
    data_readW = 32'h11111111;
    ALUresW    = 32'h22222222;
    pc4W       = 32'h33333333;
    regwriteW  = 1'b1;
    wbselW     = 2'b00;
    #1 check("sel_mem", resultW, 32'h11111111);
    tick();
    check("count_1", dut.wb_countW, 32'd1);
    check("last_mem", dut.last_resultW, 32'h11111111);

    wbselW = 2'b01;
    #1 check("sel_alu", resultW, 32'h22222222);
    tick();
    check("count_2", dut.wb_countW, 32'd2);
    check("last_alu", dut.last_resultW, 32'h22222222);

    wbselW = 2'b10;
    #1 check("sel_pc4", resultW, 32'h33333333);
    tick();
    check("count_3", dut.wb_countW, 32'd3);
    check("last_pc4", dut.last_resultW, 32'h33333333);

    // Reserved select gives zero; no write this edge so state holds.
    regwriteW = 1'b0;
    wbselW    = 2'b11;
    #1 check("sel_rsvd", resultW, 32'h00000000);
    tick();
    check("hold_count", dut.wb_countW, 32'd3);
    check("hold_last", dut.last_resultW, 32'h33333333);

    // Mid-cycle input change propagates without a clock edge.
    wbselW = 2'b01;
    #1 check("alu_before", resultW, 32'h22222222);
    ALUresW = 32'hDEADBEEF;
    #1 check("alu_midcycle", resultW, 32'hDEADBEEF);
    regwriteW = 1'b0;
    #1 check("alu_no_regwrite", resultW, 32'hDEADBEEF);

    // Bit-exact passthrough of boundary patterns (no sign extension).
    data_readW = 32'hFFFFFFFF;
    pc4W       = 32'h80000000;
    wbselW     = 2'b00;
    #1 check("mem_all_ones", resultW, 32'hFFFFFFFF);
    wbselW = 2'b10;
    #1 check("pc4_msb", resultW, 32'h80000000);
    data_readW = 32'h0000FF80;
    wbselW     = 2'b00;
    #1 check("mem_byte_pattern", resultW, 32'h0000FF80);

    // Fresh reset, three writes, then reset with regwriteW still high.
    rst = 1'b1;
    tick();
    check("rst2_count", dut.wb_countW, 32'd0);
    rst        = 1'b0;
    regwriteW  = 1'b1;
    wbselW     = 2'b00;
    data_readW = 32'hA5A5A5A5;
    tick();
    data_readW = 32'h5A5A5A5A;
    tick();
    data_readW = 32'h01234567;
    tick();
    check("three_count", dut.wb_countW, 32'd3);
    check("three_last", dut.last_resultW, 32'h01234567);

    rst = 1'b1;
    data_readW = 32'h76543210;
    #1 check("result_during_rst", resultW, 32'h76543210);
    tick();
    check("rst_prio_count", dut.wb_countW, 32'd0);
    check("rst_prio_last", dut.last_resultW, 32'd0);
    wbselW = 2'b01;
    #1 check("rst_follow_alu", resultW, 32'hDEADBEEF);

    // Writes resume counting from zero after reset releases.
    rst = 1'b0;
    tick();
    check("resume_count", dut.wb_countW, 32'd1);
    check("resume_last", dut.last_resultW, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
